// File: rtl/tlb_maint_unit_if.sv
// -----------------------------------------------------------------------------
// tlb_maint_unit_if
// Request handshake between the commit stage (master) and the TLB maintenance
// unit (slave).
//
// Handshake: the master raises req_valid_i with a stable op and operands and
// holds them until it sees req_valid_i && req_ready_o on a rising clock edge;
// that edge is the acceptance edge. req_ready_o never depends on req_valid_i.
//
// Signals:
//   req_valid_i    - maintenance op offered
//   req_ready_o    - unit can accept an op this cycle
//   req_op_i       - 0=SRCH 1=RD 2=WR 3=FILL 4=INV, 5..7 illegal
//   req_inv_op_i   - INVTLB op field
//   req_inv_asid_i - INVTLB ASID operand
//   req_inv_vpn_i  - INVTLB VPN operand
// -----------------------------------------------------------------------------
interface tlb_maint_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [4:0]  req_inv_op_i;
    logic [9:0]  req_inv_asid_i;
    logic [18:0] req_inv_vpn_i;

    modport master (
        output req_valid_i, req_op_i, req_inv_op_i, req_inv_asid_i, req_inv_vpn_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_inv_op_i, req_inv_asid_i, req_inv_vpn_i,
        output req_ready_o
    );
endinterface

// File: rtl/tlb_maint_unit.sv
// -----------------------------------------------------------------------------
// tlb_maint_unit
// Sequences one TLB maintenance instruction (TLBSRCH, TLBRD, TLBWR, TLBFILL,
// INVTLB) at a time: latches the op and the CSR snapshot on acceptance, pulses
// one MMU enable, samples the MMU response one cycle later for SRCH/RD, and
// produces one-cycle CSR write-back and done pulses.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   bus (slave)              - request handshake and INVTLB operands
//   csr_*_i                  - current CSR values, snapshotted at acceptance
//   *_en_o                   - one-cycle MMU command strobes (ISSUE state)
//   rand_idx_o               - free-running index, frozen for an in-flight FILL
//   tlbehi_o..invtlb_vpn_o   - latched operands toward the MMU
//   tlbsrch_*_i, rd_*_i      - MMU responses, valid in the WAIT cycle
//   done_o, exc_ine_o        - completion / illegal-instruction pulse (RESP)
//   csr_*_we_o, csr_*_wd_o   - CSR write-back, valid only in RESP
//   dbg_state                - current FSM state
// -----------------------------------------------------------------------------
module tlb_maint_unit #(
    parameter int  TLB_ENTRY_NUM = 32,
    localparam int IDXW = $clog2(TLB_ENTRY_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    tlb_maint_unit_if.slave   bus,

    input  logic [31:0]       csr_tlbehi_i,
    input  logic [31:0]       csr_tlbelo0_i,
    input  logic [31:0]       csr_tlbelo1_i,
    input  logic [31:0]       csr_tlbidx_i,
    input  logic [5:0]        csr_ecode_i,

    output logic              tlbsrch_en_o,
    output logic              tlbrd_en_o,
    output logic              tlbwr_en_o,
    output logic              tlbfill_en_o,
    output logic              invtlb_en_o,
    output logic [IDXW-1:0]   rand_idx_o,
    output logic [31:0]       tlbehi_o,
    output logic [31:0]       tlbelo0_o,
    output logic [31:0]       tlbelo1_o,
    output logic [31:0]       tlbidx_o,
    output logic [5:0]        ecode_o,
    output logic [4:0]        invtlb_op_o,
    output logic [9:0]        invtlb_asid_o,
    output logic [18:0]       invtlb_vpn_o,

    input  logic              tlbsrch_found_i,
    input  logic [IDXW-1:0]   tlbsrch_idx_i,
    input  logic [31:0]       rd_tlbehi_i,
    input  logic [31:0]       rd_tlbelo0_i,
    input  logic [31:0]       rd_tlbelo1_i,
    input  logic [31:0]       rd_tlbidx_i,
    input  logic [9:0]        rd_tlbasid_i,

    output logic              done_o,
    output logic              exc_ine_o,
    output logic              csr_tlbidx_we_o,
    output logic              csr_tlbehi_we_o,
    output logic              csr_tlbelo_we_o,
    output logic              csr_asid_we_o,
    output logic [31:0]       csr_tlbidx_wd_o,
    output logic [31:0]       csr_tlbehi_wd_o,
    output logic [31:0]       csr_tlbelo0_wd_o,
    output logic [31:0]       csr_tlbelo1_wd_o,
    output logic [9:0]        csr_asid_wd_o,

    output logic [1:0]        dbg_state
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic            ill_q;
    logic [IDXW-1:0] cnt;
    logic [IDXW-1:0] fill_idx_q;
    logic            fill_busy;
    logic            illegal_req;

    // Only PS and NE of the read-back index are architecturally meaningful.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{rd_tlbidx_i[30], rd_tlbidx_i[23:0]};

    assign illegal_req = (bus.req_op_i > OP_INV) ||
                         ((bus.req_op_i == OP_INV) && (bus.req_inv_op_i > 5'd6));

    assign bus.req_ready_o = (state == IDLE) && !rst;
    assign dbg_state       = state;

    // The replacement index tracks the counter, except while a FILL is in
    // flight, when it shows the value captured at acceptance.
    assign rand_idx_o = fill_busy ? fill_idx_q : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == IDXW'(TLB_ENTRY_NUM - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            op_q             <= '0;
            ill_q            <= 1'b0;
            fill_idx_q       <= '0;
            fill_busy        <= 1'b0;
            tlbsrch_en_o     <= 1'b0;
            tlbrd_en_o       <= 1'b0;
            tlbwr_en_o       <= 1'b0;
            tlbfill_en_o     <= 1'b0;
            invtlb_en_o      <= 1'b0;
            tlbehi_o         <= '0;
            tlbelo0_o        <= '0;
            tlbelo1_o        <= '0;
            tlbidx_o         <= '0;
            ecode_o          <= '0;
            invtlb_op_o      <= '0;
            invtlb_asid_o    <= '0;
            invtlb_vpn_o     <= '0;
            done_o           <= 1'b0;
            exc_ine_o        <= 1'b0;
            csr_tlbidx_we_o  <= 1'b0;
            csr_tlbehi_we_o  <= 1'b0;
            csr_tlbelo_we_o  <= 1'b0;
            csr_asid_we_o    <= 1'b0;
            csr_tlbidx_wd_o  <= '0;
            csr_tlbehi_wd_o  <= '0;
            csr_tlbelo0_wd_o <= '0;
            csr_tlbelo1_wd_o <= '0;
            csr_asid_wd_o    <= '0;
        end else begin
            // Strobes and write-back default low; each is raised for exactly
            // the one cycle that follows the edge that sets it.
            tlbsrch_en_o     <= 1'b0;
            tlbrd_en_o       <= 1'b0;
            tlbwr_en_o       <= 1'b0;
            tlbfill_en_o     <= 1'b0;
            invtlb_en_o      <= 1'b0;
            done_o           <= 1'b0;
            exc_ine_o        <= 1'b0;
            csr_tlbidx_we_o  <= 1'b0;
            csr_tlbehi_we_o  <= 1'b0;
            csr_tlbelo_we_o  <= 1'b0;
            csr_asid_we_o    <= 1'b0;
            csr_tlbidx_wd_o  <= '0;
            csr_tlbehi_wd_o  <= '0;
            csr_tlbelo0_wd_o <= '0;
            csr_tlbelo1_wd_o <= '0;
            csr_asid_wd_o    <= '0;

            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        op_q          <= bus.req_op_i;
                        tlbehi_o      <= csr_tlbehi_i;
                        tlbelo0_o     <= csr_tlbelo0_i;
                        tlbelo1_o     <= csr_tlbelo1_i;
                        tlbidx_o      <= csr_tlbidx_i;
                        ecode_o       <= csr_ecode_i;
                        invtlb_op_o   <= bus.req_inv_op_i;
                        invtlb_asid_o <= bus.req_inv_asid_i;
                        invtlb_vpn_o  <= bus.req_inv_vpn_i;
                        if (bus.req_op_i == OP_FILL) begin
                            fill_idx_q <= cnt;
                            fill_busy  <= 1'b1;
                        end
                        if (illegal_req) begin
                            // No MMU command; WAIT serves as the single hold
                            // cycle so the exception keeps a latency of 2.
                            ill_q <= 1'b1;
                            state <= WAIT;
                        end else begin
                            ill_q <= 1'b0;
                            state <= ISSUE;
                            case (bus.req_op_i)
                                OP_SRCH: tlbsrch_en_o <= 1'b1;
                                OP_RD:   tlbrd_en_o   <= 1'b1;
                                OP_WR:   tlbwr_en_o   <= 1'b1;
                                OP_FILL: tlbfill_en_o <= 1'b1;
                                default: invtlb_en_o  <= 1'b1;
                            endcase
                        end
                    end
                end

                ISSUE: begin
                    if (op_q == OP_SRCH || op_q == OP_RD) begin
                        state <= WAIT;
                    end else begin
                        state  <= RESP;
                        done_o <= 1'b1;
                    end
                end

                WAIT: begin
                    state     <= RESP;
                    done_o    <= 1'b1;
                    exc_ine_o <= ill_q;
                    if (!ill_q && op_q == OP_SRCH) begin
                        csr_tlbidx_we_o <= 1'b1;
                        if (tlbsrch_found_i) begin
                            csr_tlbidx_wd_o <= {1'b0, tlbidx_o[30:IDXW], tlbsrch_idx_i};
                        end else begin
                            csr_tlbidx_wd_o <= {1'b1, tlbidx_o[30:0]};
                        end
                    end else if (!ill_q && op_q == OP_RD) begin
                        csr_tlbidx_we_o <= 1'b1;
                        csr_tlbehi_we_o <= 1'b1;
                        csr_tlbelo_we_o <= 1'b1;
                        csr_asid_we_o   <= 1'b1;
                        if (!rd_tlbidx_i[31]) begin
                            csr_tlbidx_wd_o  <= {1'b0, tlbidx_o[30], rd_tlbidx_i[29:24],
                                                 tlbidx_o[23:0]};
                            csr_tlbehi_wd_o  <= rd_tlbehi_i;
                            csr_tlbelo0_wd_o <= rd_tlbelo0_i;
                            csr_tlbelo1_wd_o <= rd_tlbelo1_i;
                            csr_asid_wd_o    <= rd_tlbasid_i;
                        end else begin
                            // Invalid entry: clear the entry CSRs, PS=0, NE=1.
                            csr_tlbidx_wd_o  <= {1'b1, tlbidx_o[30], 6'd0, tlbidx_o[23:0]};
                        end
                    end
                end

                RESP: begin
                    state     <= IDLE;
                    fill_busy <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_maint_unit.sv
// -----------------------------------------------------------------------------
// tb_tlb_maint_unit
// Directed bench for tlb_maint_unit: each scenario task drives an op, walks it
// cycle by cycle at the falling edge and compares outputs to hand-computed
// values. Ends with a single CHECKS/ERRORS summary line.
// -----------------------------------------------------------------------------
module tb_tlb_maint_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] csr_tlbehi_i = '0, csr_tlbelo0_i = '0, csr_tlbelo1_i = '0, csr_tlbidx_i = '0;
    logic [5:0]  csr_ecode_i = '0;
    logic        tlbsrch_en_o, tlbrd_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o;
    logic [4:0]  rand_idx_o;
    logic [31:0] tlbehi_o, tlbelo0_o, tlbelo1_o, tlbidx_o;
    logic [5:0]  ecode_o;
    logic [4:0]  invtlb_op_o;
    logic [9:0]  invtlb_asid_o;
    logic [18:0] invtlb_vpn_o;
    logic        tlbsrch_found_i = 1'b0;
    logic [4:0]  tlbsrch_idx_i = '0;
    logic [31:0] rd_tlbehi_i = '0, rd_tlbelo0_i = '0, rd_tlbelo1_i = '0, rd_tlbidx_i = '0;
    logic [9:0]  rd_tlbasid_i = '0;
    logic        done_o, exc_ine_o;
    logic        csr_tlbidx_we_o, csr_tlbehi_we_o, csr_tlbelo_we_o, csr_asid_we_o;
    logic [31:0] csr_tlbidx_wd_o, csr_tlbehi_wd_o, csr_tlbelo0_wd_o, csr_tlbelo1_wd_o;
    logic [9:0]  csr_asid_wd_o;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int mcnt   = 0;

    wire [4:0] en_vec = {tlbsrch_en_o, tlbrd_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o};
    wire [3:0] we_vec = {csr_tlbidx_we_o, csr_tlbehi_we_o, csr_tlbelo_we_o, csr_asid_we_o};

    tlb_maint_unit_if bus ();

    tlb_maint_unit dut (
        .clk(clk), .rst(rst), .bus(bus),
        .csr_tlbehi_i(csr_tlbehi_i), .csr_tlbelo0_i(csr_tlbelo0_i),
        .csr_tlbelo1_i(csr_tlbelo1_i), .csr_tlbidx_i(csr_tlbidx_i), .csr_ecode_i(csr_ecode_i),
        .tlbsrch_en_o(tlbsrch_en_o), .tlbrd_en_o(tlbrd_en_o), .tlbwr_en_o(tlbwr_en_o),
        .tlbfill_en_o(tlbfill_en_o), .invtlb_en_o(invtlb_en_o), .rand_idx_o(rand_idx_o),
        .tlbehi_o(tlbehi_o), .tlbelo0_o(tlbelo0_o), .tlbelo1_o(tlbelo1_o), .tlbidx_o(tlbidx_o),
        .ecode_o(ecode_o), .invtlb_op_o(invtlb_op_o), .invtlb_asid_o(invtlb_asid_o),
        .invtlb_vpn_o(invtlb_vpn_o),
        .tlbsrch_found_i(tlbsrch_found_i), .tlbsrch_idx_i(tlbsrch_idx_i),
        .rd_tlbehi_i(rd_tlbehi_i), .rd_tlbelo0_i(rd_tlbelo0_i), .rd_tlbelo1_i(rd_tlbelo1_i),
        .rd_tlbidx_i(rd_tlbidx_i), .rd_tlbasid_i(rd_tlbasid_i),
        .done_o(done_o), .exc_ine_o(exc_ine_o),
        .csr_tlbidx_we_o(csr_tlbidx_we_o), .csr_tlbehi_we_o(csr_tlbehi_we_o),
        .csr_tlbelo_we_o(csr_tlbelo_we_o), .csr_asid_we_o(csr_asid_we_o),
        .csr_tlbidx_wd_o(csr_tlbidx_wd_o), .csr_tlbehi_wd_o(csr_tlbehi_wd_o),
        .csr_tlbelo0_wd_o(csr_tlbelo0_wd_o), .csr_tlbelo1_wd_o(csr_tlbelo1_wd_o),
        .csr_asid_wd_o(csr_asid_wd_o), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Reference replacement counter, used only to find the cycle where it is 31.
    always @(posedge clk) begin
        if (rst) mcnt <= 0;
        else     mcnt <= (mcnt == 31) ? 0 : mcnt + 1;
    end

    // Driver: called at a falling edge while the unit is idle. Presents the op,
    // lets it be accepted, then withdraws it and scrambles the CSR inputs so
    // only the latched snapshot can be used. Returns at the ISSUE-cycle negedge.
    task automatic drive_req(input logic [2:0] op, input logic [4:0] iop,
                             input logic [31:0] idx, input logic [5:0] ec);
        bus.req_valid_i    = 1'b1;
        bus.req_op_i       = op;
        bus.req_inv_op_i   = iop;
        bus.req_inv_asid_i = 10'h155;
        bus.req_inv_vpn_i  = 19'h2_1234;
        csr_tlbidx_i       = idx;
        csr_tlbehi_i       = 32'h1111_2000;
        csr_tlbelo0_i      = 32'h0000_0A5F;
        csr_tlbelo1_i      = 32'h0000_0B5F;
        csr_ecode_i        = ec;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        csr_tlbidx_i    = 32'hDEAD_BEEF;
        csr_tlbehi_i    = 32'hDEAD_BEEF;
        csr_ecode_i     = 6'h15;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({dbg_state, en_vec, we_vec, done_o, exc_ine_o, bus.req_ready_o} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0", {dbg_state, en_vec, we_vec, done_o, exc_ine_o, bus.req_ready_o});
        end
        checks++;
        if ({rand_idx_o, tlbidx_o, csr_tlbidx_wd_o, csr_asid_wd_o, ecode_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got rand=%0d idx=%h wd=%h exp 0", rand_idx_o, tlbidx_o, csr_tlbidx_wd_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", bus.req_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_srch(input logic found, input logic [31:0] exp_wd);
        drive_req(3'd0, 5'd0, 32'h0000_0003, 6'd0);
        checks++;
        if (en_vec !== 5'b10000 || dbg_state !== 2'd1 || tlbidx_o !== 32'h0000_0003) begin
            errors++;
            $display("FAIL srch_issue got en=%b st=%0d idx=%h exp 10000/1/00000003", en_vec, dbg_state, tlbidx_o);
        end
        tlbsrch_found_i = ~found;
        tlbsrch_idx_i   = 5'd17;
        @(negedge clk);
        checks++;
        if (en_vec !== 5'd0 || done_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL srch_wait got en=%b done=%b rdy=%b exp 0/0/0", en_vec, done_o, bus.req_ready_o);
        end
        tlbsrch_found_i = found;
        tlbsrch_idx_i   = 5'd9;
        @(negedge clk);
        tlbsrch_found_i = 1'b0;
        tlbsrch_idx_i   = 5'd0;
        checks++;
        if (done_o !== 1'b1 || we_vec !== 4'b1000 || csr_tlbidx_wd_o !== exp_wd || exc_ine_o !== 1'b0) begin
            errors++;
            $display("FAIL srch_resp got done=%b we=%b wd=%h exp 1/1000/%h", done_o, we_vec, csr_tlbidx_wd_o, exp_wd);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || we_vec !== 4'd0 || bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL srch_idle got done=%b we=%b rdy=%b exp 0/0/1", done_o, we_vec, bus.req_ready_o);
        end
    endtask

    task automatic test_rd(input logic [31:0] lat_idx, input logic [31:0] rd_idx,
                           input logic [31:0] exp_idx, input logic [31:0] exp_ehi,
                           input logic [9:0] exp_asid);
        drive_req(3'd1, 5'd0, lat_idx, 6'd0);
        checks++;
        if (en_vec !== 5'b01000) begin
            errors++;
            $display("FAIL rd_issue got en=%b exp 01000", en_vec);
        end
        @(negedge clk);
        rd_tlbidx_i  = rd_idx;
        rd_tlbehi_i  = 32'h7777_6000;
        rd_tlbelo0_i = 32'h0001_2345;
        rd_tlbelo1_i = 32'h0006_789A;
        rd_tlbasid_i = 10'h2AB;
        @(negedge clk);
        rd_tlbidx_i  = '0;
        rd_tlbehi_i  = '0;
        rd_tlbasid_i = '0;
        checks++;
        if (done_o !== 1'b1 || we_vec !== 4'b1111 || csr_tlbidx_wd_o !== exp_idx) begin
            errors++;
            $display("FAIL rd_idx got done=%b we=%b wd=%h exp 1/1111/%h", done_o, we_vec, csr_tlbidx_wd_o, exp_idx);
        end
        checks++;
        if (csr_tlbehi_wd_o !== exp_ehi || csr_asid_wd_o !== exp_asid ||
            csr_tlbelo0_wd_o !== (exp_ehi == 0 ? 32'h0 : 32'h0001_2345) ||
            csr_tlbelo1_wd_o !== (exp_ehi == 0 ? 32'h0 : 32'h0006_789A)) begin
            errors++;
            $display("FAIL rd_data got ehi=%h elo0=%h elo1=%h asid=%h exp ehi=%h asid=%h",
                     csr_tlbehi_wd_o, csr_tlbelo0_wd_o, csr_tlbelo1_wd_o, csr_asid_wd_o, exp_ehi, exp_asid);
        end
        @(negedge clk);
    endtask

    task automatic test_wr();
        drive_req(3'd2, 5'd0, 32'h0000_0005, 6'h3F);
        checks++;
        if (en_vec !== 5'b00100 || ecode_o !== 6'h3F || tlbehi_o !== 32'h1111_2000) begin
            errors++;
            $display("FAIL wr_issue got en=%b ecode=%h ehi=%h exp 00100/3f/11112000", en_vec, ecode_o, tlbehi_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || we_vec !== 4'd0 || en_vec !== 5'd0 || exc_ine_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got done=%b we=%b en=%b exc=%b exp 1/0/0/0", done_o, we_vec, en_vec, exc_ine_o);
        end
        @(negedge clk);
    endtask

    task automatic test_fill_wrap();
        int budget = 64;
        while (mcnt != 31 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL fill_sync got timeout exp counter 31");
        end
        drive_req(3'd3, 5'd0, 32'h0, 6'h3F);
        checks++;
        if (en_vec !== 5'b00010 || rand_idx_o !== 5'd31) begin
            errors++;
            $display("FAIL fill_issue got en=%b rand=%0d exp 00010/31", en_vec, rand_idx_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || en_vec !== 5'd0 || we_vec !== 4'd0 || rand_idx_o !== 5'd31) begin
            errors++;
            $display("FAIL fill_resp got done=%b en=%b we=%b rand=%0d exp 1/0/0/31", done_o, en_vec, we_vec, rand_idx_o);
        end
        @(negedge clk);
        // Counter wrapped to 0 at acceptance and has advanced twice since.
        checks++;
        if (rand_idx_o !== 5'd2) begin
            errors++;
            $display("FAIL fill_release got rand=%0d exp 2", rand_idx_o);
        end
    endtask

    task automatic test_inv(input logic [2:0] op, input logic [4:0] iop, input logic legal);
        drive_req(op, iop, 32'h0, 6'd0);
        checks++;
        if (en_vec !== (legal ? 5'b00001 : 5'b00000) || done_o !== 1'b0) begin
            errors++;
            $display("FAIL inv_issue got en=%b done=%b exp en=%b done=0", en_vec, done_o, legal ? 5'b00001 : 5'b00000);
        end
        if (legal) begin
            checks++;
            if (invtlb_op_o !== iop || invtlb_asid_o !== 10'h155 || invtlb_vpn_o !== 19'h2_1234) begin
                errors++;
                $display("FAIL inv_operands got op=%h asid=%h vpn=%h exp %h/155/21234", invtlb_op_o, invtlb_asid_o, invtlb_vpn_o, iop);
            end
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || exc_ine_o !== !legal || en_vec !== 5'd0 || we_vec !== 4'd0) begin
            errors++;
            $display("FAIL inv_resp got done=%b exc=%b en=%b we=%b exp 1/%b/0/0", done_o, exc_ine_o, en_vec, we_vec, !legal);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 3'd2;
        bus.req_inv_op_i = 5'd0;
        @(negedge clk);
        checks++;
        if (en_vec !== 5'b00100) begin
            errors++;
            $display("FAIL b2b_first got en=%b exp 00100", en_vec);
        end
        @(negedge clk);
        checks++;
        if (en_vec !== 5'd0 || done_o !== 1'b1 || bus.req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_held got en=%b done=%b rdy=%b exp 0/1/0", en_vec, done_o, bus.req_ready_o);
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 1'b1 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL b2b_idle got rdy=%b st=%0d exp 1/0", bus.req_ready_o, dbg_state);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        checks++;
        if (en_vec !== 5'b00100) begin
            errors++;
            $display("FAIL b2b_second got en=%b exp 00100", en_vec);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_flight();
        drive_req(3'd1, 5'd0, 32'h0000_0003, 6'd0);
        @(negedge clk);
        rst = 1'b1;
        rd_tlbidx_i = 32'h0100_0000;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || we_vec !== 4'd0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_drop got done=%b we=%b st=%0d exp 0/0/0", done_o, we_vec, dbg_state);
        end
        rst = 1'b0;
        rd_tlbidx_i = '0;
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %b exp 1", bus.req_ready_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || we_vec !== 4'd0) begin
            errors++;
            $display("FAIL rst_after got done=%b we=%b exp 0/0", done_o, we_vec);
        end
    endtask

    initial begin
        bus.req_valid_i    = 1'b0;
        bus.req_op_i       = 3'd0;
        bus.req_inv_op_i   = 5'd0;
        bus.req_inv_asid_i = '0;
        bus.req_inv_vpn_i  = '0;
        test_reset();
        test_srch(1'b1, 32'h0000_0009);
        test_srch(1'b0, 32'h8000_0003);
        test_rd(32'h0000_0003, 32'h8000_0000, 32'h8000_0003, 32'h0, 10'h0);
        test_rd(32'h4000_0003, 32'h0500_0000, 32'h4500_0003, 32'h7777_6000, 10'h2AB);
        test_wr();
        test_fill_wrap();
        test_inv(3'd4, 5'd2, 1'b1);
        test_inv(3'd4, 5'd7, 1'b0);
        test_inv(3'd6, 5'd0, 1'b0);
        test_back_to_back();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_maint_unit.md
TLB_MAINT_UNIT -- requirements
Module: tlb_maint_unit

Interface
REQ-001 SHALL have parameter TLB_ENTRY_NUM, default 32, number of TLB entries; IDXW = log2(TLB_ENTRY_NUM) = 5.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops on posedge clk.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, 1, maintenance op offered by the commit stage.
REQ-005 SHALL have port req_ready_o, output, 1, op accepted when req_valid_i and req_ready_o are high on a clock edge.
REQ-006 SHALL have port req_op_i, input, 3, 0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 are illegal.
REQ-007 SHALL have ports req_inv_op_i (5), req_inv_asid_i (10), req_inv_vpn_i (19), inputs, INVTLB operands.
REQ-008 SHALL have ports csr_tlbehi_i, csr_tlbelo0_i, csr_tlbelo1_i, csr_tlbidx_i (32 each) and csr_ecode_i (6), inputs, current CSR values.
REQ-009 SHALL have MMU-side outputs tlbsrch_en_o, tlbrd_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o (1 each), rand_idx_o (IDXW), tlbehi_o, tlbelo0_o, tlbelo1_o, tlbidx_o (32 each), ecode_o (6), invtlb_op_o (5), invtlb_asid_o (10), invtlb_vpn_o (19).
REQ-010 SHALL have MMU response inputs tlbsrch_found_i (1), tlbsrch_idx_i (IDXW), rd_tlbehi_i, rd_tlbelo0_i, rd_tlbelo1_i, rd_tlbidx_i (32 each), rd_tlbasid_i (10).
REQ-011 SHALL have outputs done_o (1), exc_ine_o (1), csr_tlbidx_we_o, csr_tlbehi_we_o, csr_tlbelo_we_o, csr_asid_we_o (1 each), and write data csr_tlbidx_wd_o, csr_tlbehi_wd_o, csr_tlbelo0_wd_o, csr_tlbelo1_wd_o (32 each) and csr_asid_wd_o (10).

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> (WAIT, SRCH/RD only) -> RESP -> IDLE; req_ready_o=1 only in IDLE.
REQ-013 SHALL latch op, operands and all csr_*_i in the acceptance cycle; later CSR input changes SHALL NOT affect the op.
REQ-014 In ISSUE, SHALL assert exactly one *_en_o for one cycle, driven from latched values; all en outputs SHALL be 0 in every other state.
REQ-015 SHALL treat MMU responses as valid in the cycle after ISSUE (WAIT) and SHALL sample them there.
REQ-016 Latency from acceptance edge to done_o: SRCH/RD 3 cycles; WR/FILL/INV 2 cycles; done_o SHALL be a one-cycle pulse in RESP.
REQ-017 CSR write enables and data SHALL be valid only in the RESP cycle.
REQ-018 rand_idx_o SHALL come from a free-running IDXW-bit counter, +1 every cycle, wrapping from TLB_ENTRY_NUM-1 to 0; the value is frozen at acceptance of FILL.
REQ-019 For SRCH with found=1: csr_tlbidx_we_o=1, wd = latched tlbidx with INDEX=tlbsrch_idx_i and NE(bit31)=0; with found=0: NE=1 and INDEX kept.
REQ-020 For RD with rd_tlbidx_i[31]=0: all four CSR write enables=1; tlbehi/elo/asid wd = rd_* values; tlbidx wd = rd PS[29:24] and NE=0, INDEX and other bits kept.
REQ-021 For RD with rd_tlbidx_i[31]=1: same enables; tlbehi, elo0, elo1 and asid wd=0; tlbidx wd has NE=1, PS=0, INDEX kept.
REQ-022 WR/FILL/INV SHALL write no CSR.
REQ-023 For INV, an inv_op > 6 SHALL skip ISSUE (no invtlb_en_o), go straight to RESP and pulse exc_ine_o with done_o; latency 2.
REQ-024 Illegal req_op_i SHALL be handled as in REQ-023.
REQ-025 ecode_o SHALL equal the latched csr_ecode_i, so FILL/WR under TLB refill (0x3F) force E=1 downstream.
REQ-026 req_valid_i while not in IDLE SHALL be ignored; the requester holds the op until accepted.

Reset
REQ-027 When rst=1 at a clock edge: FSM to IDLE, counter to 0, all en/we/done/exc outputs to 0, all data outputs to 0; an op in flight SHALL be dropped with no done_o.

Verification
REQ-028 SRCH: tlbidx=0x0000_0003 latched, found=1 with idx=9 -> done at +3; tlbidx_we=1, wd=0x0000_0009.
REQ-029 SRCH with found=0, tlbidx=0x0000_0003 -> wd=0x8000_0003.
REQ-030 RD, rd_tlbidx=0x8000_0000 -> all four CSR wd = 0 except tlbidx wd=0x8000_0003 (INDEX=3 kept); asid wd=0.
REQ-031 FILL accepted when counter=31 -> rand_idx_o=31 during ISSUE, tlbfill_en_o pulses once, counter reads 0 next cycle, done at +2, no CSR write.
REQ-032 INV with inv_op=7 -> no invtlb_en_o, done_o and exc_ine_o high at +2.
REQ-033 rst=1 during WAIT of RD -> no done_o or CSR write; req_ready_o=1 the cycle after rst goes low.
